palette_lookup_arbiter: RTL and testbench

//  Shares one combinational 16-entry palette lookup (4-bit index -> 12-bit RGB) among
//  NUM_REQ sprite/background pixel fetchers. Round-robin arbitration, one lookup per

---
 rtl/palette_lookup_arbiter_pkg.sv | 20 ++
 rtl/palette_lookup_arbiter_if.sv | 45 ++++
 rtl/palette_lookup_arbiter_rr_arbiter.sv | 33 +++
 rtl/palette_lookup_arbiter.sv | 110 +++++++++++
 tb/tb_palette_lookup_arbiter.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/palette_lookup_arbiter_pkg.sv
// Shared types and constants for the palette lookup arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package palette_arb_pkg;

   localparam int COLOR_W = 4;
   localparam int IDX_W   = 4;

   typedef logic [IDX_W-1:0] idx_t;

   typedef struct packed {
      logic [COLOR_W-1:0] red;
      logic [COLOR_W-1:0] green;
      logic [COLOR_W-1:0] blue;
   } rgb_t;

   // Index reserved as the transparency key when that feature is built in
   localparam idx_t TRANSPARENT_IDX = '0;

endpackage

// File: rtl/palette_lookup_arbiter_if.sv
// Requester, palette and response signals of the palette lookup arbiter.
// Latency: n/a (wires only); optional rsp_transparent under PAL_TRANSPARENT_EN.
// Backpressure: none; requesters hold req until grant, responses are fire-and-forget.
interface palette_lookup_arbiter_if
   import palette_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]       req;
   idx_t [NUM_REQ-1:0]       req_index;
   logic [NUM_REQ-1:0]       grant;
   idx_t                     pal_index;
   logic [COLOR_W-1:0]       pal_red;
   logic [COLOR_W-1:0]       pal_green;
   logic [COLOR_W-1:0]       pal_blue;
   logic                     rsp_valid;
   logic [ID_W-1:0]          rsp_id;
   logic [COLOR_W-1:0]       rsp_red;
   logic [COLOR_W-1:0]       rsp_green;
   logic [COLOR_W-1:0]       rsp_blue;
`ifdef PAL_TRANSPARENT_EN
   logic                     rsp_transparent;
`endif

   // Arbiter side
   modport slave (
      input  req, req_index, pal_red, pal_green, pal_blue,
      output grant, pal_index, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue
`ifdef PAL_TRANSPARENT_EN
      , output rsp_transparent
`endif
   );

   // Requester / palette side
   modport master (
      output req, req_index, pal_red, pal_green, pal_blue,
      input  grant, pal_index, rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue
`ifdef PAL_TRANSPARENT_EN
      , input rsp_transparent
`endif
   );

endinterface

// File: rtl/palette_lookup_arbiter_rr_arbiter.sv
// Round-robin picker: first set req at or after ptr (wrapping) wins.
// Latency: purely combinational.
// Backpressure: none; no req gives grant=0 and any=0.
module rr_arbiter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] win,
   output logic         any
);

   logic [W-1:0] cand;

   // scan requesters from ptr upward, wrapping at N, and stop at the first hit
   always_comb begin
      grant = '0;
      win   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = W'((int'(ptr) + k) % N);
         if (!any && req[cand]) begin
            any   = 1'b1;
            win   = cand;
            grant = {{(N-1){1'b0}}, 1'b1} << cand;
         end
      end
   end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares one palette lookup among NUM_REQ fetchers: round-robin grant, tagged response.
// Latency: grant same cycle as req; response 2 edges later; 1 lookup per cycle.
// Backpressure: none downstream; requesters hold req until grant. Option: PAL_TRANSPARENT_EN.
module palette_lookup_arbiter
   import palette_arb_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   palette_lookup_arbiter_if.slave bus
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] arb_grant;
   logic [ID_W-1:0]    arb_win;
   logic               arb_any;

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic               s1_valid_q, s1_valid_d;
   logic [ID_W-1:0]    s1_id_q, s1_id_d;
   idx_t               pal_index_q, pal_index_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
   rgb_t               rsp_rgb_q, rsp_rgb_d;
   rgb_t               pal_rgb;
`ifdef PAL_TRANSPARENT_EN
   logic               rsp_transparent_q, rsp_transparent_d;
`endif

   rr_arbiter #(.N(NUM_REQ), .W(ID_W)) u_rr (
      .req   (bus.req),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .win   (arb_win),
      .any   (arb_any)
   );

   assign pal_rgb = {bus.pal_red, bus.pal_green, bus.pal_blue};

   // grant is forced low while reset is held so no requester believes it was served
   assign bus.grant     = Reset_n ? arb_grant : '0;
   assign bus.pal_index = pal_index_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_red   = rsp_rgb_q.red;
   assign bus.rsp_green = rsp_rgb_q.green;
   assign bus.rsp_blue  = rsp_rgb_q.blue;
`ifdef PAL_TRANSPARENT_EN
   assign bus.rsp_transparent = rsp_transparent_q;
`endif

   // next state: pointer advance and stage-1 capture on grant, stage-2 capture on s1_valid
   always_comb begin
      ptr_d       = ptr_q;
      s1_valid_d  = arb_any;
      s1_id_d     = s1_id_q;
      pal_index_d = pal_index_q;
      rsp_valid_d = s1_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_rgb_d   = rsp_rgb_q;
`ifdef PAL_TRANSPARENT_EN
      rsp_transparent_d = rsp_transparent_q;
`endif
      if (arb_any) begin
         ptr_d       = (arb_win == ID_W'(NUM_REQ - 1)) ? '0 : arb_win + 1'b1;
         s1_id_d     = arb_win;
         pal_index_d = bus.req_index[arb_win];
      end
      // response fields only move with a valid lookup so idle cycles do not toggle them
      if (s1_valid_q) begin
         rsp_id_d  = s1_id_q;
         rsp_rgb_d = pal_rgb;
`ifdef PAL_TRANSPARENT_EN
         rsp_transparent_d = (pal_index_q == TRANSPARENT_IDX);
         if (pal_index_q == TRANSPARENT_IDX) begin
            rsp_rgb_d = '0;
         end
`endif
      end
   end

   // state registers; reset drops any lookup still in the pipeline
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_id_q     <= '0;
         pal_index_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rgb_q   <= '0;
`ifdef PAL_TRANSPARENT_EN
         rsp_transparent_q <= 1'b0;
`endif
      end else begin
         ptr_q       <= ptr_d;
         s1_valid_q  <= s1_valid_d;
         s1_id_q     <= s1_id_d;
         pal_index_q <= pal_index_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rgb_q   <= rsp_rgb_d;
`ifdef PAL_TRANSPARENT_EN
         rsp_transparent_q <= rsp_transparent_d;
`endif
      end
   end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: directed steps then random traffic vs a reference model.
// Latency: inputs driven 1ns after rising edge, outputs sampled on the falling edge.
// Backpressure: requesters in the random phase hold req until granted.
module tb_palette_lookup_arbiter;
   import palette_arb_pkg::*;

   localparam int N = 4;

   logic Clk;
   logic Reset_n;

   palette_lookup_arbiter_if #(.NUM_REQ(N)) bus ();

   palette_lookup_arbiter #(.NUM_REQ(N)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   // palette model: index i -> {i, ~i, i^5}
   assign bus.pal_red   = bus.pal_index;
   assign bus.pal_green = ~bus.pal_index;
   assign bus.pal_blue  = bus.pal_index ^ 4'h5;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      int due;
      int id;
      int idx;
   } rsp_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   rsp_t pend[$];
   int   m_ptr;
   int   exp_pal;
   int   last_id;
   int   last_rgb;
   int   waitc[N];

   logic [3:0]  obs_grant;
   logic [31:0] obs_pal;
   logic        obs_valid;
   logic [31:0] obs_id;
   logic [11:0] obs_rgb;
   logic        obs_transp;

   logic [31:0] b_valid[10];
   logic [31:0] b_id[10];
   logic [3:0]  b_grant[8];

   function automatic logic [11:0] exp_rgb(input int idx);
      logic [3:0] i;
      i = idx[3:0];
`ifdef PAL_TRANSPARENT_EN
      if (i == 4'd0) return 12'h000;
`endif
      return {i, ~i, i ^ 4'h5};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      pend.delete();
      m_ptr    = 0;
      exp_pal  = 0;
      last_id  = 0;
      last_rgb = 0;
      for (int r = 0; r < N; r++) waitc[r] = 0;
   endtask

   // one clock: sample at falling edge, check against model, return 1ns after next rising edge
   task automatic step();
      int win;
      @(negedge Clk);
      obs_grant  = bus.grant;
      obs_pal    = 32'(bus.pal_index);
      obs_valid  = bus.rsp_valid;
      obs_id     = 32'(bus.rsp_id);
      obs_rgb    = {bus.rsp_red, bus.rsp_green, bus.rsp_blue};
`ifdef PAL_TRANSPARENT_EN
      obs_transp = bus.rsp_transparent;
`else
      obs_transp = 1'b0;
`endif
      if (!Reset_n) begin
         model_clear();
         chk("rst_grant", 32'(obs_grant), 0);
         chk("rst_pal_index", obs_pal, 0);
         chk("rst_rsp_valid", 32'(obs_valid), 0);
         chk("rst_rsp_id", obs_id, 0);
         chk("rst_rsp_rgb", 32'(obs_rgb), 0);
         chk("rst_transparent", 32'(obs_transp), 0);
      end else begin
         chk("pal_index", obs_pal, exp_pal);
         if (pend.size() > 0 && pend[0].due == cyc) begin
            chk("rsp_valid", 32'(obs_valid), 1);
            chk("rsp_id", obs_id, pend[0].id);
            chk("rsp_rgb", 32'(obs_rgb), 32'(exp_rgb(pend[0].idx)));
`ifdef PAL_TRANSPARENT_EN
            chk("rsp_transparent", 32'(obs_transp), (pend[0].idx == 0) ? 1 : 0);
`endif
            last_id  = pend[0].id;
            last_rgb = int'(exp_rgb(pend[0].idx));
            void'(pend.pop_front());
         end else begin
            chk("rsp_idle_valid", 32'(obs_valid), 0);
            chk("rsp_hold_id", obs_id, last_id);
            chk("rsp_hold_rgb", 32'(obs_rgb), last_rgb);
         end
         win = -1;
         for (int k = 0; k < N; k++) begin
            if (win < 0 && bus.req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         end
         chk("grant", 32'(obs_grant), (win < 0) ? 0 : (1 << win));
         for (int r = 0; r < N; r++) begin
            if (bus.req[r] && r != win) waitc[r]++;
            else waitc[r] = 0;
            tests++;
            assert (waitc[r] <= N - 1) else begin
               fails++;
               $error("FAIL fairness: requester %0d waited %0d cycles, limit %0d", r, waitc[r], N - 1);
            end
         end
         if (win >= 0) begin
            pend.push_back('{due: cyc + 2, id: win, idx: int'(bus.req_index[win])});
            exp_pal = int'(bus.req_index[win]);
            m_ptr   = (win + 1) % N;
         end
      end
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   initial begin
      model_clear();
      Reset_n       = 1'b0;
      bus.req       = 4'hF;
      bus.req_index = '0;
      #1;

      // reset held with all requests up: everything quiet
      step();
      chk("t1_grant_in_reset", 32'(obs_grant), 0);
      step();
      Reset_n = 1'b1;
      step();
      chk("t1_first_grant", 32'(obs_grant), 32'h1);

      // single requester 2, index 7
      bus.req          = 4'b0100;
      bus.req_index[2] = 4'd7;
      step();
      chk("t2_grant", 32'(obs_grant), 32'h4);
      bus.req = 4'b0000;
      step();
      chk("t2_pal_index", obs_pal, 7);
      step();
      chk("t2_rsp_valid", 32'(obs_valid), 1);
      chk("t2_rsp_id", obs_id, 2);
      chk("t2_rsp_rgb", 32'(obs_rgb), 32'h782);
      step();
      chk("t2_rsp_one_cycle", 32'(obs_valid), 0);

      // park the pointer at 0 via requester 3, then all four request for 8 cycles
      bus.req = 4'b1000;
      step();
      bus.req = 4'hF;
      for (int i = 0; i < 10; i++) begin
         if (i == 8) bus.req = 4'b0000;
         bus.req_index = 16'($urandom);
         step();
         if (i < 8) b_grant[i] = obs_grant;
         b_valid[i] = 32'(obs_valid);
         b_id[i]    = obs_id;
      end
      for (int i = 0; i < 8; i++) chk("t3_grant_rotation", 32'(b_grant[i]), 32'(1 << (i % 4)));
      for (int i = 2; i < 10; i++) begin
         chk("t3_b2b_valid", b_valid[i], 1);
         chk("t3_b2b_id", b_id[i], (i - 2) % 4);
      end

      // pointer wrap: after grant to 3, requesters 0 and 3 compete
      bus.req = 4'b1001;
      step();
      chk("t4_grant0", 32'(obs_grant), 32'h1);
      bus.req = 4'b1000;
      step();
      chk("t4_grant3", 32'(obs_grant), 32'h8);
      bus.req = 4'b0000;
      step();
      step();

      // reset one cycle after a grant drops the lookup and rewinds the pointer
      bus.req = 4'b0010;
      step();
      chk("t5_grant1", 32'(obs_grant), 32'h2);
      bus.req = 4'b0000;
      Reset_n = 1'b0;
      step();
      chk("t5_no_rsp_in_reset", 32'(obs_valid), 0);
      Reset_n = 1'b1;
      step();
      chk("t5_no_rsp_after", 32'(obs_valid), 0);
      bus.req = 4'hF;
      step();
      chk("t5_ptr_rewound", 32'(obs_grant), 32'h1);
      chk("t5_no_rsp_late", 32'(obs_valid), 0);
      bus.req = 4'b0000;
      step();
      step();

      // index 0 and 1 back-to-back from a single requester
      bus.req          = 4'b0001;
      bus.req_index[0] = 4'd0;
      step();
      bus.req_index[0] = 4'd1;
      step();
      chk("t6_single_b2b_grant", 32'(obs_grant), 32'h1);
      bus.req = 4'b0000;
      step();
`ifdef PAL_TRANSPARENT_EN
      chk("t6_idx0_transparent", 32'(obs_transp), 1);
      chk("t6_idx0_rgb", 32'(obs_rgb), 32'h000);
`else
      chk("t6_idx0_rgb", 32'(obs_rgb), 32'h0F5);
`endif
      step();
      chk("t6_idx1_valid", 32'(obs_valid), 1);
      chk("t6_idx1_rgb", 32'(obs_rgb), 32'h1E4);
`ifdef PAL_TRANSPARENT_EN
      chk("t6_idx1_transparent", 32'(obs_transp), 0);
`endif

      // random traffic: granted requesters may leave, waiting ones stay, indices change freely
      for (int i = 0; i < 400; i++) begin
         logic [3:0] fresh;
         fresh = 4'($urandom);
         if ($urandom_range(0, 1) == 0) fresh = fresh & 4'($urandom);
         bus.req       = (bus.req & ~obs_grant) | fresh;
         bus.req_index = 16'($urandom);
         step();
      end
      bus.req = 4'b0000;
      step();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
